pipe_stage_skid: RTL
====================

// Module: pipe_stage_skid
// PURPOSE
// - Parametrised inter-stage pipeline register (successor to fixed D->E style latches) for the 5-stage core.
// - Carries one packed control/data payload plus a PC field with a compile-time PC offset applied on capture.
// - Adds valid/ready handshake with a 2-entry skid buffer, so back-pressure never drops an instruction.
// - Also adds flush (bubble insertion), an occupancy output and a saturating stall-cycle counter.
// PARAMETERS
// - DATA_W        default 128  width of packed payload (RD1/RD2/Imm32/Rs/Rt/Rd/control bundle)
// - PC_W          default 32   width of PC field
// - PC_OFFSET     default 4    constant added to in_pc on capture (4: PC4->PC8)
// - CLEAR_PAYLOAD default 1    1: flush/reset zero payload and PC; 0: flush clears valid only
// - CNT_W         default 16   width of stall-cycle counter
// PORTS
// - clk           in   1        rising-edge clock
// - reset         in   1        asynchronous, active-low reset
// - flush         in   1        synchronous kill of all held entries (stall-reset / bubble)
// - in_valid      in   1        upstream entry valid
// - in_ready      out  1        stage can accept this cycle
// - in_data       in   DATA_W   upstream payload
// - in_pc         in   PC_W     upstream PC value
// - out_valid     out  1        head entry valid
// - out_ready     in   1        downstream accepts head
// - out_data      out  DATA_W   head payload
// - out_pc        out  PC_W     head PC (in_pc + PC_OFFSET, mod 2^PC_W)
// - occupancy     out  2        held entries, 0..2
// - stall_cycles  out  CNT_W    cycles with out_valid && !out_ready, saturating
// BEHAVIOUR
// - Reset (reset=0, async): all valids 0, out_data/out_pc 0, occupancy 0, stall_cycles 0; in_ready=1.
// - in_fire = in_valid && in_ready; out_fire = out_valid && out_ready.
// - in_ready = !skid_valid (from registered state only; never from out_ready: no comb in->out path).
// - Latency 1 cycle when empty: entry captured at edge N is on out_* after edge N.
// - occ 0: in_fire -> head <= in, occ 1.
// - occ 1: in_fire&&out_fire -> head <= in, occ 1; in_fire only -> skid <= in, occ 2;
//   out_fire only -> occ 0; neither -> hold.
// - occ 2: in_ready=0; out_fire -> head <= skid, skid cleared, occ 1; else hold.
// - Order strictly FIFO; head stable (data and pc) while out_valid && !out_ready.
// - flush highest priority: next state occ 0 regardless of in_fire/out_fire; a same-cycle
//   incoming entry is dropped; the current head still counts as delivered if out_fire.
//   CLEAR_PAYLOAD=1 zeroes head/skid payload and PC; =0 leaves stale payload with valid 0.
// - PC: stored value = in_pc + PC_OFFSET, truncated to PC_W (wraps 0xFFFFFFFC+4 -> 0).
// - stall_cycles increments each cycle out_valid && !out_ready; saturates at 2^CNT_W-1; cleared
//   only by reset, unaffected by flush.
// - Reset asserted mid-transfer: immediate clear; first post-reset in_fire is occ 0 case.
// - occupancy = head_valid + skid_valid; encoding 2'b11 never occurs (assertion).
// STRUCTURE
// - Shared package pipe_pkg: OCC_EMPTY/OCC_ONE/OCC_FULL constants, default DATA_W bundle typedef
//   for the D/E payload, PC_STEP constant (4).
// - One sub-module: pipe_slot (valid + payload + pc register with load/clear, async active-low reset),
//   instanced twice (head, skid); top holds next-state control and stall counter.
// TESTING
// - Reset: reset=0 mid-stream with occ 2 -> next sample out_valid=0, occupancy=0, in_ready=1, stall_cycles=0.
// - Streaming: out_ready=1, in_valid=1 for 8 cycles, in_pc=0x3000+4k -> out_pc=0x3004+4k, one per cycle, 1-cycle lag.
// - Back-pressure: out_ready=0 after A,B accepted -> occupancy=2, in_ready=0, C not taken; out_ready=1 ->
//   A,B,C delivered in order, stall_cycles equals stalled cycles.
// - Flush: occ 2 + in_valid + flush=1 -> next cycle occupancy=0, out_valid=0, out_data=0 (CLEAR_PAYLOAD=1).
// - PC wrap: in_pc=0xFFFFFFFC -> out_pc=0x00000000; CNT_W=2 with 5 stall cycles -> stall_cycles=3.
// - Random valid/ready/flush vs scoreboard 10k cycles: no loss, no duplication, FIFO order.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for inter-stage pipeline registers of the 5-stage core.
package pipe_pkg;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;

    localparam int unsigned PC_STEP = 4;

    // Default D/E payload: register operands, immediate, register specifiers, control bundle.
    typedef struct packed {
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm32;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [16:0] ctrl;
    } de_bundle_t;

    localparam int unsigned DE_DATA_W = $bits(de_bundle_t);

    function automatic logic [1:0] occ_of(input logic head_v, input logic skid_v);
        return {1'b0, head_v} + {1'b0, skid_v};
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry: valid flag plus payload and PC, with load / drop / kill controls.
module pipe_slot #(
    parameter int unsigned DATA_W        = 128,
    parameter int unsigned PC_W          = 32,
    parameter bit          CLEAR_PAYLOAD = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              drop,
    input  logic              kill,
    input  logic [DATA_W-1:0] load_data,
    input  logic [PC_W-1:0]   load_pc,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [PC_W-1:0]   pc
);

    // kill (flush) wins over load; drop only retires the entry and keeps the payload.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= 1'b0;
            data  <= '0;
            pc    <= '0;
        end else if (kill) begin
            valid <= 1'b0;
            if (CLEAR_PAYLOAD) begin
                data <= '0;
                pc   <= '0;
            end
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            pc    <= load_pc;
        end else if (drop) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, 2-entry skid, flush and stall counter.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W        = DE_DATA_W,
    parameter int unsigned PC_W          = 32,
    parameter int unsigned PC_OFFSET     = PC_STEP,
    parameter bit          CLEAR_PAYLOAD = 1'b1,
    parameter int unsigned CNT_W         = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [PC_W-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [PC_W-1:0]   out_pc,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cycles
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              head_valid, skid_valid;
    logic [DATA_W-1:0] head_data, skid_data;
    logic [PC_W-1:0]   head_pc, skid_pc;

    logic              head_load, head_drop, head_kill, head_from_skid;
    logic              skid_load, skid_drop, skid_kill;
    logic [DATA_W-1:0] head_load_data;
    logic [PC_W-1:0]   head_load_pc;
    logic [PC_W-1:0]   cap_pc;
    logic              in_fire, out_fire;

    assign in_ready  = !skid_valid;
    assign out_valid = head_valid;
    assign out_data  = head_data;
    assign out_pc    = head_pc;
    assign occupancy = occ_of(head_valid, skid_valid);

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign cap_pc   = in_pc + PC_W'(PC_OFFSET);

    // Next-state control: flush empties both slots; otherwise the occupancy decides.
    always_comb begin
        head_load      = 1'b0;
        head_drop      = 1'b0;
        head_kill      = 1'b0;
        head_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_drop      = 1'b0;
        skid_kill      = 1'b0;
        if (flush) begin
            head_kill = 1'b1;
            skid_kill = 1'b1;
        end else begin
            case (occupancy)
                OCC_EMPTY: begin
                    head_load = in_fire;
                end
                OCC_ONE: begin
                    if (in_fire && out_fire) begin
                        head_load = 1'b1;
                    end else if (in_fire) begin
                        skid_load = 1'b1;
                    end else if (out_fire) begin
                        head_drop = 1'b1;
                    end
                end
                OCC_FULL: begin
                    if (out_fire) begin
                        head_load      = 1'b1;
                        head_from_skid = 1'b1;
                        skid_drop      = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign head_load_data = head_from_skid ? skid_data : in_data;
    assign head_load_pc   = head_from_skid ? skid_pc   : cap_pc;

    pipe_slot #(
        .DATA_W        (DATA_W),
        .PC_W          (PC_W),
        .CLEAR_PAYLOAD (CLEAR_PAYLOAD)
    ) u_head (
        .clk       (clk),
        .reset     (reset),
        .load      (head_load),
        .drop      (head_drop),
        .kill      (head_kill),
        .load_data (head_load_data),
        .load_pc   (head_load_pc),
        .valid     (head_valid),
        .data      (head_data),
        .pc        (head_pc)
    );

    pipe_slot #(
        .DATA_W        (DATA_W),
        .PC_W          (PC_W),
        .CLEAR_PAYLOAD (CLEAR_PAYLOAD)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .load      (skid_load),
        .drop      (skid_drop),
        .kill      (skid_kill),
        .load_data (in_data),
        .load_pc   (cap_pc),
        .valid     (skid_valid),
        .data      (skid_data),
        .pc        (skid_pc)
    );

    // Saturating count of back-pressured cycles; flush does not touch it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles <= '0;
        end else if (out_valid && !out_ready && (stall_cycles != CNT_MAX)) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

    a_occ_legal: assert property (@(posedge clk) disable iff (!reset) occupancy != 2'b11);
    a_skid_has_head: assert property (@(posedge clk) disable iff (!reset) !(skid_valid && !head_valid));

endmodule
